uart_rx_sampler: RTL and testbench

Front end of the UART receive path, directly upstream of the RX framing FSM.
- Synchronises the asynchronous serial input and generates the mid-bit sample strobe.
- Majority-filters three oversamples per bit.
- Presents the sampled line level plus a one-cycle sample enable to the FSM.
- The FSM's counter-hold output, RXCT_R, phase-aligns the bit timing to the start edge.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_rx_sampler.sv | 101 ++++++++++
 tb/tb_uart_rx_sampler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and helpers: idle level, default oversampling,
// prescaler divisor calculation and the majority-vote window.
package uart_pkg;

  localparam logic        UART_IDLE_LVL    = 1'b1;
  localparam int unsigned UART_DEFAULT_OVS = 16;

  // Rounded clocks per oversample tick; a result of 0 is rejected at elaboration.
  function automatic int unsigned calc_div(int unsigned clk_freq, int unsigned baud,
                                           int unsigned ovs);
    int unsigned den;
    den = baud * ovs;
    return (clk_freq + den / 2) / den;
  endfunction

  // Vote window is centred on the mid-bit oversample: OVS/2-2 .. OVS/2.
  function automatic int unsigned vote_first(int unsigned ovs);
    return ovs / 2 - 2;
  endfunction

  function automatic int unsigned vote_last(int unsigned ovs);
    return ovs / 2;
  endfunction

  function automatic logic maj3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable
// reset level so the chain powers up at the line's idle state.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronises RXD, times oversample ticks, majority-votes
// three mid-bit samples and hands the result to the framing FSM with a strobe.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115_200,
  parameter int unsigned OVS      = UART_DEFAULT_OVS
) (
  input  logic CLK,
  input  logic RST,
  input  logic RXD,
  input  logic RXCT_R,
  output logic RXD_RG,
  output logic RX_CE,
  output logic OS_TICK
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVS);
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OW  = $clog2(OVS);

  localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV - 1);
  localparam logic [OW-1:0] OS_MAX     = OW'(OVS - 1);
  localparam logic [OW-1:0] VOTE_FIRST = OW'(vote_first(OVS));
  localparam logic [OW-1:0] VOTE_LAST  = OW'(vote_last(OVS));

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_sampler: CLK_FREQ/(BAUD*OVS) rounds to zero");
  end
  if ((OVS < 8) || (OVS % 2 != 0)) begin : g_bad_ovs
    $error("uart_rx_sampler: OVS must be even and at least 8");
  end

  logic          rxd_s;
  logic [PW-1:0] presc_q, presc_d;
  logic [OW-1:0] os_cnt_q, os_cnt_d;
  logic [2:0]    vote_q, vote_d;
  logic          rxd_rg_q, rxd_rg_d;
  logic          rx_ce_q, rx_ce_d;
  logic          os_tick;

  sync_2ff #(
    .RESET_VAL(UART_IDLE_LVL)
  ) u_sync_rxd (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (RXD),
    .q_o  (rxd_s)
  );

  // Gating by RXCT_R means a hold-to-run transition never sees a stale tick.
  assign os_tick = ~RST & ~RXCT_R & (presc_q == PRESC_MAX);

  always_comb begin
    presc_d  = presc_q;
    os_cnt_d = os_cnt_q;
    vote_d   = vote_q;
    rxd_rg_d = rxd_rg_q;
    rx_ce_d  = 1'b0;
    if (RXCT_R) begin
      presc_d  = '0;
      os_cnt_d = '0;
      rxd_rg_d = rxd_s;
    end else begin
      presc_d = os_tick ? '0 : presc_q + 1'b1;
      if (os_tick) begin
        os_cnt_d = (os_cnt_q == OS_MAX) ? '0 : os_cnt_q + 1'b1;
        if ((os_cnt_q >= VOTE_FIRST) && (os_cnt_q <= VOTE_LAST)) begin
          vote_d = {vote_q[1:0], rxd_s};
        end
        // Third sample joins the vote directly rather than waiting a cycle.
        if (os_cnt_q == VOTE_LAST) begin
          rx_ce_d  = 1'b1;
          rxd_rg_d = maj3(vote_q[1], vote_q[0], rxd_s);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q  <= '0;
      os_cnt_q <= '0;
      vote_q   <= {3{UART_IDLE_LVL}};
      rxd_rg_q <= UART_IDLE_LVL;
      rx_ce_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      os_cnt_q <= os_cnt_d;
      vote_q   <= vote_d;
      rxd_rg_q <= rxd_rg_d;
      rx_ce_q  <= rx_ce_d;
    end
  end

  assign RXD_RG  = rxd_rg_q;
  assign RX_CE   = rx_ce_q;
  assign OS_TICK = os_tick;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler at DIV=10, OVS=16 (160-cycle bit).
module tb_uart_rx_sampler;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int unsigned OVS      = 16;
  localparam int          BITC     = 160;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic rxd    = 1'b1;
  logic rxct_r = 1'b1;
  logic rxd_rg, rx_ce, os_tick;

  uart_rx_sampler #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .OVS     (OVS)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .RXD    (rxd),
    .RXCT_R (rxct_r),
    .RXD_RG (rxd_rg),
    .RX_CE  (rx_ce),
    .OS_TICK(os_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    at;
    logic  val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   ce_count   = 0;
  int   tick_count = 0;
  bit   tick_chk   = 1'b0;
  int   t_run      = 0;

  task automatic check(input string name, input logic actual, input logic expv);
    n_checks++;
    if (actual !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, actual, expv, cyc);
    end
  endtask

  task automatic check_int(input string name, input int actual, input int expv);
    n_checks++;
    if (actual != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expv, cyc);
    end
  endtask

  // Monitor: every RX_CE must match the next scoreboard entry in cycle and level.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rx_ce) begin
        ce_count++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rx_ce: got RX_CE=1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check_int({e.name, "_ce_cycle"}, cyc, e.at);
          check({e.name, "_rxd_rg"}, rxd_rg, e.val);
        end
      end
      if (tick_chk && os_tick) begin
        tick_count++;
        check_int("os_tick_phase", (cyc - t_run) % 10, 9);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  // Drives one frame with the start edge on the RXCT_R fall; glitch windows force RXD low.
  task automatic run_frame(input string name, input logic [15:0] bits, input int nbits,
                           input logic [15:0] expv, input int g1_lo, input int g1_hi,
                           input int g2_lo, input int g2_hi);
    int   t;
    logic b;
    exp_t e;
    t      = cyc;
    t_run  = t;
    rxct_r = 1'b0;
    for (int n = 0; n < nbits; n++) begin
      e.at   = t + BITC * n + 90;
      e.val  = expv[n];
      e.name = $sformatf("%s_bit%0d", name, n);
      sb.push_back(e);
    end
    for (int c = 0; c < nbits * BITC; c++) begin
      b = bits[c / BITC];
      if ((c >= g1_lo && c < g1_hi) || (c >= g2_lo && c < g2_hi)) b = 1'b0;
      rxd = b;
      step();
    end
    rxct_r = 1'b1;
    rxd    = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   t;
    int   ce_snap;

    // Reset values while RST is held.
    wait_n(3);
    @(negedge clk);
    check("reset_rxd_rg", rxd_rg, 1'b1);
    check("reset_rx_ce", rx_ce, 1'b0);
    check("reset_os_tick", os_tick, 1'b0);

    // Run with RXD low, then hit reset right after the first strobe.
    step();
    rst = 1'b0;
    step();
    t      = cyc;
    rxct_r = 1'b0;
    rxd    = 1'b0;
    e.at   = t + 90;
    e.val  = 1'b0;
    e.name = "pre_reset";
    sb.push_back(e);
    wait_n(90);
    #6;
    rst = 1'b1;
    #1;
    check("async_reset_rx_ce", rx_ce, 1'b0);
    check("async_reset_os_tick", os_tick, 1'b0);
    check("async_reset_rxd_rg", rxd_rg, 1'b1);
    rxct_r = 1'b1;
    rxd    = 1'b1;
    wait_n(3);
    rst     = 1'b0;
    ce_snap = ce_count;
    wait_n(1000);
    check_int("hold_no_rx_ce", ce_count - ce_snap, 0);

    // Idle tracking: RXD to RXD_RG takes three cycles in hold mode.
    ce_snap = ce_count;
    wait_n(100);
    rxd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("idle_fall_d%0d", k), rxd_rg, (k < 3) ? 1'b1 : 1'b0);
    end
    step();
    rxd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("idle_rise_d%0d", k), rxd_rg, (k < 3) ? 1'b0 : 1'b1);
    end
    step();
    wait_n(20);
    check_int("idle_no_rx_ce", ce_count - ce_snap, 0);

    // Byte 0xA5, even parity 0, stop 1; OS_TICK phase checked on every tick.
    tick_count = 0;
    tick_chk   = 1'b1;
    run_frame("byte_a5", {5'd0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 16'b00000_10101001010,
              -1, -1, -1, -1);
    tick_chk = 1'b0;
    check_int("os_tick_count", tick_count, 176);
    wait_n(200);

    // Glitches: one sample hit in bit 1 (out-voted), all three hit in bit 2.
    run_frame("glitch", 16'b1110, 4, 16'b1010, 232, 242, 382, 412);
    wait_n(200);

    // False start aborted after 50 cycles; counters must clear on the next edge.
    ce_snap = ce_count;
    rxct_r  = 1'b0;
    rxd     = 1'b0;
    wait_n(50);
    rxct_r = 1'b1;
    rxd    = 1'b1;
    step();
    @(negedge clk);
    check_int("abort_presc_clear", int'(dut.presc_q), 0);
    check_int("abort_os_cnt_clear", int'(dut.os_cnt_q), 0);
    check("abort_os_tick", os_tick, 1'b0);
    step();
    wait_n(200);
    check_int("abort_no_rx_ce", ce_count - ce_snap, 0);
    run_frame("restart", 16'h0000, 1, 16'h0000, -1, -1, -1, -1);
    wait_n(200);

    check_int("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
